// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel coordinates, syncs, blanking
// and line/frame markers, all registered and advanced by a pixel clock-enable.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   COORD_W   = 10,
  parameter int   FRAME_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PIXEL_EN,
  output logic [COORD_W-1:0] HCOORD,
  output logic [COORD_W-1:0] VCOORD,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               VIDEO_ON,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic [FRAME_W-1:0] FRAME_CNT
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2**COORD_W || V_TOTAL > 2**COORD_W || H_SYNC == 0 || V_SYNC == 0)
  begin : g_illegal_params
    $error("vga_timing_gen: raster does not fit COORD_W or a sync width is zero");
  end

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  // Region bounds carry one extra bit so an end bound equal to 2**COORD_W still compares.
  localparam logic [COORD_W:0] H_VIS_END  = (COORD_W+1)'(H_VISIBLE);
  localparam logic [COORD_W:0] HS_START   = (COORD_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W:0] HS_END     = (COORD_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W:0] V_VIS_END  = (COORD_W+1)'(V_VISIBLE);
  localparam logic [COORD_W:0] VS_START   = (COORD_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W:0] VS_END     = (COORD_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] h_nxt;
  logic [COORD_W-1:0] v_nxt;
  logic               hs_act_nxt;
  logic               vs_act_nxt;
  logic               video_nxt;
  logic               line_start_nxt;
  logic               frame_start_nxt;
  logic [FRAME_W-1:0] frame_cnt_nxt;

  // PIXEL_EN is a plain advance strobe, not a handshake: sampled every CLK,
  // one step per cycle it is high, nothing is back-pressured.
  always_comb begin
    h_nxt = HCOORD;
    v_nxt = VCOORD;
    if (PIXEL_EN) begin
      if (HCOORD == H_LAST) begin
        h_nxt = '0;
        v_nxt = (VCOORD == V_LAST) ? '0 : VCOORD + COORD_W'(1);
      end else begin
        h_nxt = HCOORD + COORD_W'(1);
      end
    end
  end

  // Decodes look at the next coordinates so every registered flag lines up
  // with the coordinate it describes.
  always_comb begin
    hs_act_nxt      = ({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END);
    vs_act_nxt      = ({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END);
    video_nxt       = ({1'b0, h_nxt} < H_VIS_END) && ({1'b0, v_nxt} < V_VIS_END);
    line_start_nxt  = PIXEL_EN && (h_nxt == '0);
    frame_start_nxt = line_start_nxt && (v_nxt == '0);
    frame_cnt_nxt   = frame_start_nxt ? FRAME_CNT + FRAME_W'(1) : FRAME_CNT;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      HCOORD      <= H_LAST;
      VCOORD      <= V_LAST;
      HSYNC       <= ~HSYNC_POL;
      VSYNC       <= ~VSYNC_POL;
      VIDEO_ON    <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= '1;
    end else begin
      HCOORD      <= h_nxt;
      VCOORD      <= v_nxt;
      HSYNC       <= hs_act_nxt ? HSYNC_POL : ~HSYNC_POL;
      VSYNC       <= vs_act_nxt ? VSYNC_POL : ~VSYNC_POL;
      VIDEO_ON    <= video_nxt;
      LINE_START  <= line_start_nxt;
      FRAME_START <= frame_start_nxt;
      FRAME_CNT   <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x525 instance and a small 12x7 instance
// share reset and pixel-enable; both are checked every cycle against a raster model.
module tb_vga_timing_gen;

  typedef struct {
    int hv, hf, hs, hb;
    int vv, vf, vs, vb;
    int hpol, vpol, fw;
  } cfg_t;

  typedef struct {
    int h, v, hs, vs, vid, ls, fs, fc;
  } out_t;

  localparam cfg_t BIG   = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8};
  localparam cfg_t SMALL = '{8, 1, 2, 1, 4, 1, 1, 1, 1, 0, 2};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pixel_en = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] b_h, b_v;
  logic       b_hs, b_vs, b_vid, b_ls, b_fs;
  logic [7:0] b_fc;
  logic [3:0] s_h, s_v;
  logic       s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [1:0] s_fc;

  vga_timing_gen dut_big (
    .CLK(clk), .RST(rst), .PIXEL_EN(pixel_en),
    .HCOORD(b_h), .VCOORD(b_v), .HSYNC(b_hs), .VSYNC(b_vs),
    .VIDEO_ON(b_vid), .LINE_START(b_ls), .FRAME_START(b_fs), .FRAME_CNT(b_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .COORD_W(4), .FRAME_W(2)
  ) dut_small (
    .CLK(clk), .RST(rst), .PIXEL_EN(pixel_en),
    .HCOORD(s_h), .VCOORD(s_v), .HSYNC(s_hs), .VSYNC(s_vs),
    .VIDEO_ON(s_vid), .LINE_START(s_ls), .FRAME_START(s_fs), .FRAME_CNT(s_fc)
  );

  // scoreboard state
  int  n_tests = 0;
  int  n_fail  = 0;
  int  steps   = 0;   // enabled steps since the last reset
  bit  stepped = 0;   // last edge performed a step
  int  hs_count = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (steps=%0d)", tag, obs, exp, steps);
    end
  endtask

  // Reference raster: step k (k>=1) shows linear pixel k-1 of an endless
  // sequence of frames; the reset state is pixel -1, i.e. the last pixel of frame -1.
  function automatic out_t model(input cfg_t c, input int n, input bit st);
    out_t o;
    int ht, vt, fp, idx, pix, frame;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    fp = ht * vt;
    idx = n - 1 + fp;
    pix = idx % fp;
    frame = idx / fp - 1;
    o.h   = pix % ht;
    o.v   = pix / ht;
    o.hs  = (o.h >= c.hv + c.hf && o.h < c.hv + c.hf + c.hs) ? c.hpol : 1 - c.hpol;
    o.vs  = (o.v >= c.vv + c.vf && o.v < c.vv + c.vf + c.vs) ? c.vpol : 1 - c.vpol;
    o.vid = (o.h < c.hv && o.v < c.vv) ? 1 : 0;
    o.ls  = (st && o.h == 0) ? 1 : 0;
    o.fs  = (st && o.h == 0 && o.v == 0) ? 1 : 0;
    o.fc  = frame & ((1 << c.fw) - 1);
    return o;
  endfunction

  task automatic compare_all();
    out_t eb, es;
    eb = model(BIG, steps, stepped);
    es = model(SMALL, steps, stepped);
    check("big.hcoord", int'(b_h), eb.h);
    check("big.vcoord", int'(b_v), eb.v);
    check("big.hsync", int'(b_hs), eb.hs);
    check("big.vsync", int'(b_vs), eb.vs);
    check("big.video_on", int'(b_vid), eb.vid);
    check("big.line_start", int'(b_ls), eb.ls);
    check("big.frame_start", int'(b_fs), eb.fs);
    check("big.frame_cnt", int'(b_fc), eb.fc);
    check("small.hcoord", int'(s_h), es.h);
    check("small.vcoord", int'(s_v), es.v);
    check("small.hsync", int'(s_hs), es.hs);
    check("small.vsync", int'(s_vs), es.vs);
    check("small.video_on", int'(s_vid), es.vid);
    check("small.line_start", int'(s_ls), es.ls);
    check("small.frame_start", int'(s_fs), es.fs);
    check("small.frame_cnt", int'(s_fc), es.fc);
  endtask

  // driver: inputs change just after a falling edge, outputs are checked on the next one
  task automatic drive(input bit r, input bit p);
    rst = r;
    pixel_en = p;
    if (r) begin
      steps = 0;
      stepped = 0;
    end else if (p) begin
      steps++;
      stepped = 1;
    end else begin
      stepped = 0;
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    @(negedge clk);
    compare_all();
    drive(1, 1);
    drive(1, 1);
    check("rst.hcoord", int'(b_h), 799);
    check("rst.vcoord", int'(b_v), 524);
    check("rst.frame_cnt", int'(b_fc), 255);
    check("rst.hsync_idle", int'(b_hs), 1);

    // continuous run: first step lands on (0,0) with both markers
    drive(0, 1);
    check("first.hcoord", int'(b_h), 0);
    check("first.vcoord", int'(b_v), 0);
    check("first.frame_start", int'(b_fs), 1);
    check("first.line_start", int'(b_ls), 1);
    check("first.video_on", int'(b_vid), 1);
    check("first.frame_cnt", int'(b_fc), 0);
    if (b_hs == 1'b0) hs_count++;
    for (int i = 1; i < 2000; i++) begin
      drive(0, 1);
      if (b_hs == 1'b0) hs_count++;
    end
    // two full lines of 96 sync pixels; line 2 stops at pixel 399
    check("line.hsync_cycles", hs_count, 192);

    // half-rate enable
    for (int i = 0; i < 1700; i++) drive(0, (i % 2) == 0);

    // mid-line reset, hold, then restart
    drive(1, 1);
    drive(0, 0);
    check("midrst.hcoord", int'(b_h), 799);
    check("midrst.vcoord", int'(b_v), 524);
    check("midrst.video_on", int'(b_vid), 0);
    drive(0, 1);
    check("midrst.first_h", int'(b_h), 0);
    check("midrst.first_fc", int'(b_fc), 0);

    // randomized enable with occasional resets
    for (int i = 0; i < 20000; i++)
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
